// File: rtl/fifo_read_serializer.sv
// Read-domain drain engine: pops whole words from a first-word-fall-through FIFO
// and streams each one as RATIO narrower beats, LSB slice first, with no bubbles.
module fifo_read_serializer #(
  parameter int WIDTH       = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   read_clk,
  input  logic                   read_reset,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_read_data,
  output logic                   fifo_read_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_last,
  output logic [COUNT_WIDTH-1:0] words_drained
);

  localparam int RATIO = WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [WIDTH-1:0]       word_buf_q, word_buf_d;
  logic [IDX_W-1:0]       beat_idx_q, beat_idx_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   acc, wdone;

  assign out_valid     = (state_q == SEND);
  assign acc           = out_valid && out_ready;
  assign wdone         = acc && (beat_idx_q == LAST_IDX);
  // out_ready reaches only the pop strobe, so a finishing word can hand over
  // to the next one in the same cycle.
  assign fifo_read_en  = !read_reset && !fifo_empty && ((state_q == IDLE) || wdone);

  assign out_data      = word_buf_q[OUT_WIDTH*int'(beat_idx_q) +: OUT_WIDTH];
  assign out_last      = out_valid && (beat_idx_q == LAST_IDX);
  assign words_drained = cnt_q;

  always_comb begin
    state_d    = state_q;
    word_buf_d = word_buf_q;
    beat_idx_d = beat_idx_q;
    cnt_d      = cnt_q;
    if (fifo_read_en) begin
      word_buf_d = fifo_read_data;
      beat_idx_d = '0;
      state_d    = SEND;
      cnt_d      = cnt_q + COUNT_WIDTH'(1);
    end else if (wdone) begin
      state_d    = IDLE;
    end else if (acc) begin
      beat_idx_d = beat_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      state_q    <= IDLE;
      word_buf_q <= '0;
      beat_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      word_buf_q <= word_buf_d;
      beat_idx_q <= beat_idx_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Bench for fifo_read_serializer: a 4:1 instance and a 1:1 instance with a 4-bit
// counter, both checked cycle by cycle against a queue-of-beats reference model.
module tb_fifo_read_serializer;

  logic        read_clk = 1'b0;
  logic        read_reset;
  logic        fifo_empty;
  logic [31:0] fifo_read_data;
  logic        out_ready;

  logic        pop0, v0, last0;
  logic [7:0]  d0;
  logic [15:0] c0;
  logic        pop1, v1, last1;
  logic [31:0] d1;
  logic [3:0]  c1;

  bit          sel;
  logic        obs_pop, obs_valid, obs_last;
  logic [31:0] obs_data, obs_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] fq[$];
  logic [31:0] mq[$];
  logic [31:0] mcnt;

  always #5 read_clk = ~read_clk;

  fifo_read_serializer #(.WIDTH(32), .OUT_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .read_clk(read_clk), .read_reset(read_reset), .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data), .fifo_read_en(pop0), .out_valid(v0),
    .out_ready(out_ready), .out_data(d0), .out_last(last0), .words_drained(c0));

  fifo_read_serializer #(.WIDTH(32), .OUT_WIDTH(32), .COUNT_WIDTH(4)) dut1 (
    .read_clk(read_clk), .read_reset(read_reset), .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data), .fifo_read_en(pop1), .out_valid(v1),
    .out_ready(out_ready), .out_data(d1), .out_last(last1), .words_drained(c1));

  assign obs_pop   = sel ? pop1  : pop0;
  assign obs_valid = sel ? v1    : v0;
  assign obs_last  = sel ? last1 : last0;
  assign obs_data  = sel ? d1    : {24'h0, d0};
  assign obs_cnt   = sel ? {28'h0, c1} : {16'h0, c0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entered and left at posedge+1; checks land mid-cycle.
  task automatic step(input bit rdy, input bit rst);
    int          ratio;
    int          ow;
    logic [31:0] omask, cmask, w;
    bit          ev, ep;
    ratio = sel ? 1 : 4;
    ow    = sel ? 32 : 8;
    omask = sel ? 32'hFFFF_FFFF : 32'h0000_00FF;
    cmask = sel ? 32'h0000_000F : 32'h0000_FFFF;
    out_ready      = rdy;
    read_reset     = rst;
    fifo_empty     = (fq.size() == 0);
    fifo_read_data = fifo_empty ? $urandom : fq[0];
    #4;
    ev = (mq.size() != 0);
    ep = !rst && !fifo_empty && (!ev || (rdy && mq.size() == 1));
    chk("pop",   {31'h0, obs_pop},   {31'h0, ep});
    chk("valid", {31'h0, obs_valid}, {31'h0, ev});
    chk("last",  {31'h0, obs_last},  {31'h0, ev && mq.size() == 1});
    if (ev) chk("data", obs_data, mq[0]);
    chk("count", obs_cnt, mcnt);
    @(posedge read_clk);
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (ev && rdy) void'(mq.pop_front());
      if (ep) begin
        w = fq.pop_front();
        for (int k = 0; k < ratio; k++) mq.push_back((w >> (k*ow)) & omask);
        mcnt = (mcnt + 1) & cmask;
      end
    end
    #1;
  endtask

  task automatic run(input int n, input bit rdy);
    repeat (n) step(rdy, 1'b0);
  endtask

  task automatic raw_reset();
    read_reset     = 1'b1;
    fifo_empty     = 1'b0;
    fifo_read_data = $urandom;
    out_ready      = 1'b1;
    @(posedge read_clk); #1;
    chk("rst_pop", {31'h0, obs_pop}, 32'h0);
    @(posedge read_clk); #1;
    read_reset = 1'b0;
    fifo_empty = 1'b1;
    fq.delete();
    mq.delete();
    mcnt = 0;
    chk("rst_valid", {31'h0, obs_valid}, 32'h0);
    chk("rst_data",  obs_data, 32'h0);
    chk("rst_last",  {31'h0, obs_last}, 32'h0);
    chk("rst_count", obs_cnt, 32'h0);
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      if (fq.size() < 8 && $urandom_range(0, 2) != 0) fq.push_back($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
  endtask

  initial begin
    sel = 1'b0;
    mcnt = 0;
    read_reset = 1'b1; fifo_empty = 1'b1; fifo_read_data = '0; out_ready = 1'b0;
    @(posedge read_clk); #1;

    // single word
    raw_reset();
    fq.push_back(32'hA1B2_C3D4);
    run(6, 1'b1);
    chk("t1_count", obs_cnt, 32'd1);
    chk("t1_idle",  {31'h0, obs_valid}, 32'h0);

    // back-to-back words
    raw_reset();
    fq.push_back(32'h1122_3344);
    fq.push_back(32'h5566_7788);
    run(10, 1'b1);
    chk("t2_count", obs_cnt, 32'd2);

    // backpressure on beat 2
    raw_reset();
    fq.push_back(32'hA1B2_C3D4);
    fq.push_back(32'h1234_5678);
    run(3, 1'b1);
    repeat (3) begin
      chk("t3_hold", obs_data, 32'hB2);
      step(1'b0, 1'b0);
    end
    run(10, 1'b1);

    // FIFO empty at word end, later word
    raw_reset();
    fq.push_back(32'h0102_0304);
    run(8, 1'b1);
    chk("t4_idle", {31'h0, obs_valid}, 32'h0);
    fq.push_back(32'hCAFE_F00D);
    step(1'b1, 1'b0);
    chk("t4_b0", obs_data, 32'h0D);
    run(5, 1'b1);

    // reset mid-word
    raw_reset();
    fq.push_back(32'hDEAD_BEEF);
    fq.push_back(32'h0BAD_F00D);
    run(3, 1'b1);
    step(1'b1, 1'b1);
    chk("t5_valid", {31'h0, obs_valid}, 32'h0);
    chk("t5_count", obs_cnt, 32'h0);
    step(1'b1, 1'b0);
    chk("t5_b0", obs_data, 32'h0D);
    run(6, 1'b1);

    raw_reset();
    rand_run(500);

    // 1:1 ratio, 4-bit counter wrap
    sel = 1'b1;
    raw_reset();
    for (int i = 0; i < 17; i++) fq.push_back($urandom);
    run(19, 1'b1);
    chk("t6_count", obs_cnt, 32'd1);
    chk("t6_idle",  {31'h0, obs_valid}, 32'h0);

    raw_reset();
    rand_run(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
